// File: rtl/roc_output_tx.sv
// UART 8N1 framer: on i_send, snapshot i_roc_outputs and send A5, LEN, payload (LSB byte first), optional CHK.
// Optional checksum byte (XOR of LEN and payload) is enabled by defining ROC_TX_CHECKSUM_EN.
module roc_output_tx #(
    parameter int CLK_FREQ         = 50_000_000,
    parameter int BAUD             = 115_200,
    parameter int ROC_OUTPUTS      = 8,
    parameter int ROC_OUTPUT_BYTES = (ROC_OUTPUTS + 7) >> 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [ROC_OUTPUTS-1:0] i_roc_outputs,
    input  logic                   i_send,
    output logic                   o_tx,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int SNAP_W       = ROC_OUTPUT_BYTES * 8;

    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    HDR      = 8'hA5;
    localparam logic [7:0]    LEN      = 8'(ROC_OUTPUT_BYTES);
    localparam logic [8:0]    LAST_PAY = 9'(ROC_OUTPUT_BYTES + 1);
`ifdef ROC_TX_CHECKSUM_EN
    localparam logic [8:0]    LAST_IDX = 9'(ROC_OUTPUT_BYTES + 2);
`else
    localparam logic [8:0]    LAST_IDX = LAST_PAY;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              r_state,    w_state;
    logic [CW-1:0]       r_clk_cnt,  w_clk_cnt;
    logic [2:0]          r_bit_cnt,  w_bit_cnt;
    logic [8:0]          r_byte_idx, w_byte_idx;
    logic [7:0]          r_shift,    w_shift;
    logic [SNAP_W-1:0]   r_snap,     w_snap;
    logic [7:0]          r_chk,      w_chk;
    logic                r_tx,       w_tx;
    logic                r_busy,     w_busy;
    logic                r_done,     w_done;
    logic                r_pend,     w_pend;
    logic                w_load;
    logic                w_bit_end;
    logic [8:0]          w_next_idx;

    always_comb begin
        w_state    = r_state;
        w_clk_cnt  = r_clk_cnt;
        w_bit_cnt  = r_bit_cnt;
        w_byte_idx = r_byte_idx;
        w_shift    = r_shift;
        w_snap     = r_snap;
        w_chk      = r_chk;
        w_tx       = r_tx;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_pend     = r_pend;
        w_load     = 1'b0;
        w_bit_end  = (r_clk_cnt == CNT_MAX);
        w_next_idx = r_byte_idx + 9'd1;

        // Requests while a frame is in flight coalesce into one pending flag.
        if (i_send && r_busy)
            w_pend = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (i_send)
                    w_load = 1'b1;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_clk_cnt = '0;
                    w_bit_cnt = 3'd0;
                    w_state   = S_DATA;
                    w_tx      = r_shift[0];
                end else begin
                    w_clk_cnt = r_clk_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_clk_cnt = '0;
                    if (r_bit_cnt == 3'd7) begin
                        w_state = S_STOP;
                        w_tx    = 1'b1;
                    end else begin
                        w_bit_cnt = r_bit_cnt + 1'b1;
                        w_shift   = {1'b0, r_shift[7:1]};
                        w_tx      = r_shift[1];
                    end
                end else begin
                    w_clk_cnt = r_clk_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_clk_cnt = '0;
                    if (r_byte_idx == LAST_IDX) begin
                        w_done = 1'b1;
                        if (r_pend || i_send) begin
                            w_load = 1'b1;
                        end else begin
                            w_state = S_IDLE;
                            w_busy  = 1'b0;
                        end
                    end else begin
                        w_byte_idx = w_next_idx;
                        w_state    = S_START;
                        w_tx       = 1'b0;
                        // Payload drains from the snapshot low byte first; checksum accumulates as it goes.
                        if (w_next_idx == 9'd1) begin
                            w_shift = LEN;
                        end else if (w_next_idx <= LAST_PAY) begin
                            w_shift = r_snap[7:0];
                            w_snap  = r_snap >> 8;
                            w_chk   = r_chk ^ r_snap[7:0];
                        end else begin
                            w_shift = r_chk;
                        end
                    end
                end else begin
                    w_clk_cnt = r_clk_cnt + 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_tx    = 1'b1;
                w_busy  = 1'b0;
            end
        endcase

        // Frame launch: header start bit goes out the cycle after the request.
        if (w_load) begin
            w_state    = S_START;
            w_tx       = 1'b0;
            w_busy     = 1'b1;
            w_pend     = 1'b0;
            w_clk_cnt  = '0;
            w_bit_cnt  = 3'd0;
            w_byte_idx = 9'd0;
            w_shift    = HDR;
            w_chk      = LEN;
            w_snap     = '0;
            w_snap[ROC_OUTPUTS-1:0] = i_roc_outputs;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= 3'd0;
            r_byte_idx <= 9'd0;
            r_shift    <= 8'd0;
            r_snap     <= '0;
            r_chk      <= 8'd0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pend     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_clk_cnt  <= w_clk_cnt;
            r_bit_cnt  <= w_bit_cnt;
            r_byte_idx <= w_byte_idx;
            r_shift    <= w_shift;
            r_snap     <= w_snap;
            r_chk      <= w_chk;
            r_tx       <= w_tx;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_pend     <= w_pend;
        end
    end

    assign o_tx   = r_tx;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_roc_output_tx.sv
// Directed bench for roc_output_tx at 10 clocks/bit: 12-bit instance (2 payload bytes) and 1-bit instance.
module tb_roc_output_tx;

`ifdef ROC_TX_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    localparam int NB_A = 4 + CHK;
    localparam int NB_B = 3 + CHK;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] roc_a = 12'h000;
    logic        send_a = 1'b0;
    logic        tx_a, busy_a, done_a;
    logic [0:0]  roc_b = 1'b0;
    logic        send_b = 1'b0;
    logic        tx_b, busy_b, done_b;

    always #5 clk = ~clk;

    roc_output_tx #(.CLK_FREQ(10), .BAUD(1), .ROC_OUTPUTS(12)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_roc_outputs(roc_a), .i_send(send_a),
        .o_tx(tx_a), .o_busy(busy_a), .o_done(done_a)
    );

    roc_output_tx #(.CLK_FREQ(10), .BAUD(1), .ROC_OUTPUTS(1)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_roc_outputs(roc_b), .i_send(send_b),
        .o_tx(tx_b), .o_busy(busy_b), .o_done(done_b)
    );

    int         n_checks = 0;
    int         n_err    = 0;
    logic       tx_log [0:599];
    logic [7:0] rx     [0:7];
    int         bad_busy;
    int         frame_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse send for one cycle; returns at the negedge of the first frame cycle.
    task automatic start(input bit sel);
        @(negedge clk);
        if (sel) send_b = 1'b1;
        else     send_a = 1'b1;
        @(negedge clk);
        send_a = 1'b0;
        send_b = 1'b0;
    endtask

    // Record one frame cycle by cycle, then decode bytes and check bit framing/timing.
    task automatic capture(input bit sel, input int nbytes, input bit inject);
        logic v;
        bad_busy  = 0;
        frame_err = 0;
        for (int i = 0; i < nbytes * 100; i++) begin
            tx_log[i] = sel ? tx_b : tx_a;
            if ((sel ? busy_b : busy_a) !== 1'b1) bad_busy++;
            if (i > 0 && (sel ? done_b : done_a) !== 1'b0) bad_busy++;
            if (inject) begin
                send_a = (i == 50 || i == 120 || i == 200);
                if (i == 100) roc_a = 12'h123;
            end
            @(negedge clk);
        end
        send_a = 1'b0;
        for (int k = 0; k < nbytes; k++) begin
            for (int j = 0; j < 10; j++) begin
                v = tx_log[k*100 + j*10];
                for (int c = 1; c < 10; c++)
                    if (tx_log[k*100 + j*10 + c] !== v) frame_err++;
                if (j == 0 && v !== 1'b0) frame_err++;
                if (j == 9 && v !== 1'b1) frame_err++;
                if (j >= 1 && j <= 8) rx[k][j-1] = v;
            end
        end
    endtask

    task automatic check_frame(input string tag, input int nbytes,
                               input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                               input logic [7:0] e3, input logic [7:0] e4);
        logic [7:0] exp [0:4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3; exp[4] = e4;
        check_eq($sformatf("%s_timing", tag), frame_err, 0);
        check_eq($sformatf("%s_busy", tag), bad_busy, 0);
        for (int k = 0; k < nbytes; k++)
            check_eq($sformatf("%s_b%0d", tag, k), {24'd0, rx[k]}, {24'd0, exp[k]});
    endtask

    initial begin
        int bad;
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_tx", tx_a, 1'b1);
        check_eq("rst_busy", busy_a, 1'b0);
        check_eq("rst_done", done_a, 1'b0);
        rst = 1'b0;

        // Idle for 500 cycles
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) bad++;
        end
        check_eq("idle_500", bad, 0);

        // Single frame, outputs=ABC
        roc_a = 12'hABC;
        start(1'b0);
        check_eq("t2_start_tx", tx_a, 1'b0);
        check_eq("t2_start_busy", busy_a, 1'b1);
        capture(1'b0, NB_A, 1'b0);
        check_eq("t2_done", done_a, 1'b1);
        check_eq("t2_busy_drop", busy_a, 1'b0);
        check_eq("t2_idle_tx", tx_a, 1'b1);
        check_frame("t2", NB_A, 8'hA5, 8'h02, 8'hBC, 8'h0A, 8'hB4);
        @(negedge clk);
        check_eq("t2_done_pulse", done_a, 1'b0);

        // Coalesced requests mid-frame, outputs changed mid-frame
        roc_a = 12'hABC;
        start(1'b0);
        capture(1'b0, NB_A, 1'b1);
        check_eq("t4_done1", done_a, 1'b1);
        check_eq("t4_busy_held", busy_a, 1'b1);
        check_eq("t4_b2b_start", tx_a, 1'b0);
        check_frame("t4f1", NB_A, 8'hA5, 8'h02, 8'hBC, 8'h0A, 8'hB4);
        capture(1'b0, NB_A, 1'b0);
        check_eq("t4_done2", done_a, 1'b1);
        check_eq("t4_busy_drop", busy_a, 1'b0);
        check_frame("t4f2", NB_A, 8'hA5, 8'h02, 8'h23, 8'h01, 8'h20);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy_a !== 1'b0 || tx_a !== 1'b1) bad++;
        end
        check_eq("t4_no_third", bad, 0);

        // Reset mid-frame
        roc_a = 12'h5A3;
        start(1'b0);
        repeat (149) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("t5_async_tx", tx_a, 1'b1);
        check_eq("t5_async_busy", busy_a, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done_a !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        check_eq("t5_no_done", bad, 0);
        start(1'b0);
        capture(1'b0, NB_A, 1'b0);
        check_eq("t5_done", done_a, 1'b1);
        check_frame("t5", NB_A, 8'hA5, 8'h02, 8'hA3, 8'h05, 8'hA4);

        // Single-bit output vector
        roc_b = 1'b1;
        start(1'b1);
        check_eq("t6_start_tx", tx_b, 1'b0);
        capture(1'b1, NB_B, 1'b0);
        check_eq("t6_done", done_b, 1'b1);
        check_frame("t6", NB_B, 8'hA5, 8'h01, 8'h01, 8'h00, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
